// File: rtl/mem_pkg.sv
// Shared types for the cache-to-main_mem path: request tags, request kinds,
// block address/data containers and the per-cache controller state.
package mem_pkg;

  localparam int BLOCK_DATA_W = 128;
  localparam int BLOCK_ADDR_W = 26;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } cache_type_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_ctrl_state_t;

  typedef logic [BLOCK_DATA_W-1:0] block_data_t;
  typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is the icache, bit 1 the dcache.
// The priority pointer only moves on a contested grant, and then it points
// at the requester that just lost.
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_aL,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  cache_type_t ptr;

  // Uncontested requests pass straight through; a tie is broken by the pointer.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (ptr == ICACHE) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Hand priority to the loser after each contested grant.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      ptr <= ICACHE;
    end else if (req == 2'b11) begin
      ptr <= (ptr == ICACHE) ? DCACHE : ICACHE;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller between the L1 caches and main_mem. Arbitrates one
// outstanding block request per cache onto the single main_mem port and
// routes tagged responses back to the requesting cache.
// Optional build macro MEM_CTRL_PERF_CNT_EN adds saturating request counters.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 ic_req_valid,
  output logic                 ic_req_ready,
  input  main_mem_block_addr_t ic_req_block_addr,
  output logic                 ic_resp_valid,
  output block_data_t          ic_resp_block_data,
  input  logic                 dc_req_valid,
  output logic                 dc_req_ready,
  input  req_type_t            dc_req_type,
  input  main_mem_block_addr_t dc_req_block_addr,
  input  block_data_t          dc_req_block_data,
  output logic                 dc_resp_valid,
  output block_data_t          dc_resp_block_data,
  output logic                 mem_req_valid,
  output cache_type_t          mem_req_cache_type,
  output req_type_t            mem_req_type,
  output main_mem_block_addr_t mem_req_block_addr,
  output block_data_t          mem_req_block_data,
  input  logic                 mem_resp_valid,
  input  cache_type_t          mem_resp_cache_type,
  input  block_data_t          mem_resp_block_data,
  output logic                 err_spurious_resp
`ifdef MEM_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     perf_ic_rd_cnt,
  output logic [CNT_W-1:0]     perf_dc_rd_cnt,
  output logic [CNT_W-1:0]     perf_dc_wr_cnt
`endif
);

  mem_ctrl_state_t      ic_state, ic_state_nxt;
  mem_ctrl_state_t      dc_state, dc_state_nxt;
  logic [1:0]           arb_req, arb_gnt;
  logic                 ic_resp_hit, dc_resp_hit, spurious;

  logic                 req_valid_p1;
  cache_type_t          req_cache_type_p1;
  req_type_t            req_type_p1;
  main_mem_block_addr_t req_addr_p1;
  block_data_t          req_data_p1;
  logic                 ic_resp_valid_p1, dc_resp_valid_p1;
  block_data_t          ic_resp_data_p1, dc_resp_data_p1;
  logic                 err_p1;

  // Only an idle cache may compete; main_mem never stalls, so grant == accept.
  assign arb_req      = {dc_req_valid && (dc_state == IDLE),
                         ic_req_valid && (ic_state == IDLE)};
  assign ic_req_ready = arb_gnt[0];
  assign dc_req_ready = arb_gnt[1];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_aL (rst_aL),
    .req    (arb_req),
    .gnt    (arb_gnt)
  );

  assign ic_resp_hit = mem_resp_valid && (mem_resp_cache_type == ICACHE) && (ic_state == WAIT);
  assign dc_resp_hit = mem_resp_valid && (mem_resp_cache_type == DCACHE) && (dc_state == WAIT);
  assign spurious    = mem_resp_valid && !ic_resp_hit && !dc_resp_hit;

  // Per-cache state: idle until accepted, waiting until its tagged response.
  always_comb begin
    ic_state_nxt = ic_state;
    dc_state_nxt = dc_state;
    case (ic_state)
      IDLE:    if (ic_req_ready) ic_state_nxt = WAIT;
      WAIT:    if (ic_resp_hit)  ic_state_nxt = IDLE;
      default: ic_state_nxt = IDLE;
    endcase
    case (dc_state)
      IDLE:    if (dc_req_ready) dc_state_nxt = WAIT;
      WAIT:    if (dc_resp_hit)  dc_state_nxt = IDLE;
      default: dc_state_nxt = IDLE;
    endcase
  end

  // State registers for both per-cache FSMs.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      ic_state <= IDLE;
      dc_state <= IDLE;
    end else begin
      ic_state <= ic_state_nxt;
      dc_state <= dc_state_nxt;
    end
  end

  // p0 -> p1: register the granted request; valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      req_valid_p1      <= 1'b0;
      req_cache_type_p1 <= ICACHE;
      req_type_p1       <= READ;
      req_addr_p1       <= '0;
      req_data_p1       <= '0;
    end else begin
      req_valid_p1 <= ic_req_ready || dc_req_ready;
      if (dc_req_ready) begin
        req_cache_type_p1 <= DCACHE;
        req_type_p1       <= dc_req_type;
        req_addr_p1       <= dc_req_block_addr;
        req_data_p1       <= dc_req_block_data;
      end else if (ic_req_ready) begin
        req_cache_type_p1 <= ICACHE;
        req_type_p1       <= READ;
        req_addr_p1       <= ic_req_block_addr;
        req_data_p1       <= '0;
      end
    end
  end

  // p0 -> p1: register routed responses; stray responses latch the error flag.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      ic_resp_valid_p1 <= 1'b0;
      dc_resp_valid_p1 <= 1'b0;
      ic_resp_data_p1  <= '0;
      dc_resp_data_p1  <= '0;
      err_p1           <= 1'b0;
    end else begin
      ic_resp_valid_p1 <= ic_resp_hit;
      dc_resp_valid_p1 <= dc_resp_hit;
      if (ic_resp_hit) ic_resp_data_p1 <= mem_resp_block_data;
      if (dc_resp_hit) dc_resp_data_p1 <= mem_resp_block_data;
      if (spurious)    err_p1          <= 1'b1;
    end
  end

  assign mem_req_valid      = req_valid_p1;
  assign mem_req_cache_type = req_cache_type_p1;
  assign mem_req_type       = req_type_p1;
  assign mem_req_block_addr = req_addr_p1;
  assign mem_req_block_data = req_data_p1;
  assign ic_resp_valid      = ic_resp_valid_p1;
  assign ic_resp_block_data = ic_resp_data_p1;
  assign dc_resp_valid      = dc_resp_valid_p1;
  assign dc_resp_block_data = dc_resp_data_p1;
  assign err_spurious_resp  = err_p1;

`ifdef MEM_CTRL_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count accepted requests per kind, holding at all-ones.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      perf_ic_rd_cnt <= '0;
      perf_dc_rd_cnt <= '0;
      perf_dc_wr_cnt <= '0;
    end else begin
      if (ic_req_ready)                          perf_ic_rd_cnt <= sat_inc(perf_ic_rd_cnt);
      if (dc_req_ready && (dc_req_type == READ))  perf_dc_rd_cnt <= sat_inc(perf_dc_rd_cnt);
      if (dc_req_ready && (dc_req_type == WRITE)) perf_dc_wr_cnt <= sat_inc(perf_dc_wr_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small main_mem model: fixed response
// latency, pre-write read data, and an injection path for stray responses.
module tb_mem_ctrl;
  import mem_pkg::*;

  logic                 clk;
  logic                 rst_aL;
  logic                 ic_req_valid;
  logic                 ic_req_ready;
  main_mem_block_addr_t ic_req_block_addr;
  logic                 ic_resp_valid;
  block_data_t          ic_resp_block_data;
  logic                 dc_req_valid;
  logic                 dc_req_ready;
  req_type_t            dc_req_type;
  main_mem_block_addr_t dc_req_block_addr;
  block_data_t          dc_req_block_data;
  logic                 dc_resp_valid;
  block_data_t          dc_resp_block_data;
  logic                 mem_req_valid;
  cache_type_t          mem_req_cache_type;
  req_type_t            mem_req_type;
  main_mem_block_addr_t mem_req_block_addr;
  block_data_t          mem_req_block_data;
  logic                 mem_resp_valid;
  cache_type_t          mem_resp_cache_type;
  block_data_t          mem_resp_block_data;
  logic                 err_spurious_resp;
`ifdef MEM_CTRL_PERF_CNT_EN
  logic [31:0]          perf_ic_rd_cnt, perf_dc_rd_cnt, perf_dc_wr_cnt;
`endif

  int n_asserts;
  int n_fails;

  mem_ctrl #(.CNT_W(32)) dut (
    .clk                 (clk),
    .rst_aL              (rst_aL),
    .ic_req_valid        (ic_req_valid),
    .ic_req_ready        (ic_req_ready),
    .ic_req_block_addr   (ic_req_block_addr),
    .ic_resp_valid       (ic_resp_valid),
    .ic_resp_block_data  (ic_resp_block_data),
    .dc_req_valid        (dc_req_valid),
    .dc_req_ready        (dc_req_ready),
    .dc_req_type         (dc_req_type),
    .dc_req_block_addr   (dc_req_block_addr),
    .dc_req_block_data   (dc_req_block_data),
    .dc_resp_valid       (dc_resp_valid),
    .dc_resp_block_data  (dc_resp_block_data),
    .mem_req_valid       (mem_req_valid),
    .mem_req_cache_type  (mem_req_cache_type),
    .mem_req_type        (mem_req_type),
    .mem_req_block_addr  (mem_req_block_addr),
    .mem_req_block_data  (mem_req_block_data),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_cache_type (mem_resp_cache_type),
    .mem_resp_block_data (mem_resp_block_data),
    .err_spurious_resp   (err_spurious_resp)
`ifdef MEM_CTRL_PERF_CNT_EN
    ,
    .perf_ic_rd_cnt      (perf_ic_rd_cnt),
    .perf_dc_rd_cnt      (perf_dc_rd_cnt),
    .perf_dc_wr_cnt      (perf_dc_wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main_mem model: response valid 6 cycles after mem_req_valid, carrying
  // the data stored before any write in the same request.
  block_data_t mem_arr [0:255];
  logic [5:0]  pv;
  cache_type_t pt [0:5];
  block_data_t pd [0:5];
  logic        force_valid;
  cache_type_t force_tag;
  block_data_t force_data;

  always @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      pv <= '0;
      for (int i = 0; i < 256; i++)
        mem_arr[i] <= (i == 16) ? {16{8'hA5}} : {16{8'(i)}};
    end else begin
      pv    <= {pv[4:0], mem_req_valid};
      pt[0] <= mem_req_cache_type;
      pd[0] <= mem_arr[mem_req_block_addr[7:0]];
      for (int i = 1; i < 6; i++) begin
        pt[i] <= pt[i-1];
        pd[i] <= pd[i-1];
      end
      if (mem_req_valid && (mem_req_type == WRITE))
        mem_arr[mem_req_block_addr[7:0]] <= mem_req_block_data;
    end
  end

  assign mem_resp_valid      = pv[5] | force_valid;
  assign mem_resp_cache_type = force_valid ? force_tag  : pt[5];
  assign mem_resp_block_data = force_valid ? force_data : pd[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk1({pfx, "_ic_ready"}, ic_req_ready, 1'b0);
    chk1({pfx, "_dc_ready"}, dc_req_ready, 1'b0);
    chk1({pfx, "_mem_valid"}, mem_req_valid, 1'b0);
    chk1({pfx, "_mem_tag"}, mem_req_cache_type, 1'b0);
    chk1({pfx, "_mem_type"}, mem_req_type, 1'b0);
    chkw({pfx, "_mem_addr"}, BLOCK_DATA_W'(mem_req_block_addr), '0);
    chkw({pfx, "_mem_data"}, mem_req_block_data, '0);
    chk1({pfx, "_ic_resp"}, ic_resp_valid, 1'b0);
    chkw({pfx, "_ic_data"}, ic_resp_block_data, '0);
    chk1({pfx, "_dc_resp"}, dc_resp_valid, 1'b0);
    chkw({pfx, "_dc_data"}, dc_resp_block_data, '0);
    chk1({pfx, "_err"}, err_spurious_resp, 1'b0);
`ifdef MEM_CTRL_PERF_CNT_EN
    chkw({pfx, "_perf_ic_rd"}, 128'(perf_ic_rd_cnt), '0);
    chkw({pfx, "_perf_dc_rd"}, 128'(perf_dc_rd_cnt), '0);
    chkw({pfx, "_perf_dc_wr"}, 128'(perf_dc_wr_cnt), '0);
`endif
  endtask

  initial begin
    n_asserts         = 0;
    n_fails           = 0;
    rst_aL            = 1'b0;
    ic_req_valid      = 1'b0;
    ic_req_block_addr = '0;
    dc_req_valid      = 1'b0;
    dc_req_type       = READ;
    dc_req_block_addr = '0;
    dc_req_block_data = '0;
    force_valid       = 1'b0;
    force_tag         = ICACHE;
    force_data        = '0;

    // Reset state
    repeat (3) tick();
    chk_all_zero("rst");
    rst_aL = 1'b1;
    tick();

    // Single icache read of 0x10
    ic_req_valid = 1'b1; ic_req_block_addr = 26'h10; #1;
    chk1("t1_ic_ready", ic_req_ready, 1'b1);
    chk1("t1_dc_ready", dc_req_ready, 1'b0);
    tick(); ic_req_valid = 1'b0;
    chk1("t1_mem_valid", mem_req_valid, 1'b1);
    chk1("t1_mem_tag", mem_req_cache_type, ICACHE);
    chk1("t1_mem_type", mem_req_type, READ);
    chkw("t1_mem_addr", BLOCK_DATA_W'(mem_req_block_addr), 128'h10);
    chkw("t1_mem_data", mem_req_block_data, '0);
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk1($sformatf("t1_ic_resp_c%0d", k), ic_resp_valid, k == 8);
      chk1($sformatf("t1_dc_resp_c%0d", k), dc_resp_valid, 1'b0);
      if (k == 2) chk1("t1_mem_valid_pulse", mem_req_valid, 1'b0);
      if (k == 8) chkw("t1_ic_data", ic_resp_block_data, {16{8'hA5}});
    end

    // dcache write then read of the same block
    dc_req_valid = 1'b1; dc_req_type = WRITE;
    dc_req_block_addr = 26'h20; dc_req_block_data = 128'h1234; #1;
    chk1("t2_wr_ready", dc_req_ready, 1'b1);
    tick();
    chk1("t2_mem_valid", mem_req_valid, 1'b1);
    chk1("t2_mem_tag", mem_req_cache_type, DCACHE);
    chk1("t2_mem_type", mem_req_type, WRITE);
    chkw("t2_mem_addr", BLOCK_DATA_W'(mem_req_block_addr), 128'h20);
    chkw("t2_mem_data", mem_req_block_data, 128'h1234);
    dc_req_type = READ; #1;
    chk1("t2_rd_blocked_c1", dc_req_ready, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk1($sformatf("t2_ack_c%0d", k), dc_resp_valid, k == 8);
      chk1($sformatf("t2_rd_ready_c%0d", k), dc_req_ready, k == 8);
    end
    tick(); dc_req_valid = 1'b0;
    chk1("t2_rd_mem_valid", mem_req_valid, 1'b1);
    chk1("t2_rd_mem_type", mem_req_type, READ);
    chkw("t2_rd_mem_addr", BLOCK_DATA_W'(mem_req_block_addr), 128'h20);
    for (int k = 10; k <= 16; k++) begin
      tick();
      chk1($sformatf("t2_rd_resp_c%0d", k), dc_resp_valid, k == 16);
      if (k == 16) chkw("t2_rd_data", dc_resp_block_data, 128'h1234);
    end

    // Contested requests straight out of reset
    rst_aL = 1'b0;
    tick(); rst_aL = 1'b1;
    tick();
    ic_req_valid = 1'b1; ic_req_block_addr = 26'h30;
    dc_req_valid = 1'b1; dc_req_type = READ; dc_req_block_addr = 26'h40; #1;
    chk1("t3_ic_wins", ic_req_ready, 1'b1);
    chk1("t3_dc_loses", dc_req_ready, 1'b0);
    tick(); ic_req_valid = 1'b0; #1;
    chk1("t3_mem_tag_ic", mem_req_cache_type, ICACHE);
    chkw("t3_mem_addr_ic", BLOCK_DATA_W'(mem_req_block_addr), 128'h30);
    chk1("t3_dc_next", dc_req_ready, 1'b1);
    tick(); dc_req_valid = 1'b0;
    chk1("t3_mem_valid_dc", mem_req_valid, 1'b1);
    chk1("t3_mem_tag_dc", mem_req_cache_type, DCACHE);
    chkw("t3_mem_addr_dc", BLOCK_DATA_W'(mem_req_block_addr), 128'h40);
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk1($sformatf("t3_ic_resp_c%0d", k), ic_resp_valid, k == 8);
      chk1($sformatf("t3_dc_resp_c%0d", k), dc_resp_valid, k == 9);
    end
    tick();
    ic_req_valid = 1'b1; ic_req_block_addr = 26'h31;
    dc_req_valid = 1'b1; dc_req_block_addr = 26'h41; #1;
    chk1("t3b_dc_wins", dc_req_ready, 1'b1);
    chk1("t3b_ic_loses", ic_req_ready, 1'b0);
    tick(); dc_req_valid = 1'b0; #1;
    chk1("t3b_mem_tag_dc", mem_req_cache_type, DCACHE);
    chkw("t3b_mem_addr_dc", BLOCK_DATA_W'(mem_req_block_addr), 128'h41);
    chk1("t3b_ic_next", ic_req_ready, 1'b1);
    tick(); ic_req_valid = 1'b0;
    chk1("t3b_mem_tag_ic", mem_req_cache_type, ICACHE);
    repeat (8) tick();

    // Back-to-back icache reads
    ic_req_valid = 1'b1; ic_req_block_addr = 26'h1; #1;
    chk1("t4_first_ready", ic_req_ready, 1'b1);
    tick(); ic_req_block_addr = 26'h2; #1;
    chkw("t4_mem_addr1", BLOCK_DATA_W'(mem_req_block_addr), 128'h1);
    chk1("t4_second_blocked", ic_req_ready, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk1($sformatf("t4_resp1_c%0d", k), ic_resp_valid, k == 8);
      if (k == 8) begin
        chkw("t4_data1", ic_resp_block_data, {16{8'h01}});
        chk1("t4_second_ready", ic_req_ready, 1'b1);
      end
    end
    tick(); ic_req_valid = 1'b0;
    chk1("t4_mem_valid2", mem_req_valid, 1'b1);
    chkw("t4_mem_addr2", BLOCK_DATA_W'(mem_req_block_addr), 128'h2);
    for (int k = 10; k <= 16; k++) begin
      tick();
      chk1($sformatf("t4_resp2_c%0d", k), ic_resp_valid, k == 16);
      if (k == 16) chkw("t4_data2", ic_resp_block_data, {16{8'h02}});
    end

    // Stray dcache response while dcache is idle
    tick();
    chk1("t5_err_before", err_spurious_resp, 1'b0);
    force_valid = 1'b1; force_tag = DCACHE; force_data = {8{16'hDEAD}};
    tick(); force_valid = 1'b0;
    chk1("t5_no_dc_resp", dc_resp_valid, 1'b0);
    chk1("t5_no_ic_resp", ic_resp_valid, 1'b0);
    chk1("t5_err_set", err_spurious_resp, 1'b1);
    repeat (3) tick();
    chk1("t5_err_sticky", err_spurious_resp, 1'b1);
    chk1("t5_no_dc_resp_late", dc_resp_valid, 1'b0);

    // Reset while icache is waiting
    ic_req_valid = 1'b1; ic_req_block_addr = 26'h10; #1;
    chk1("t6_ready", ic_req_ready, 1'b1);
    tick(); ic_req_valid = 1'b0;
    tick();
`ifdef MEM_CTRL_PERF_CNT_EN
    chkw("t6_perf_ic_rd", 128'(perf_ic_rd_cnt), 128'd5);
    chkw("t6_perf_dc_rd", 128'(perf_dc_rd_cnt), 128'd2);
    chkw("t6_perf_dc_wr", 128'(perf_dc_wr_cnt), 128'd0);
`endif
    rst_aL = 1'b0; #1;
    chk_all_zero("t6_rst");
    tick(); rst_aL = 1'b1; #1;
    ic_req_valid = 1'b1; #1;
    chk1("t6_ready_after", ic_req_ready, 1'b1);
    ic_req_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk1($sformatf("t6_no_late_resp_c%0d", k), ic_resp_valid, 1'b0);
    end
    chk1("t6_mem_quiet", mem_req_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
